// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order single-issue dispatch controller.
// Tracks pending register writes in a scoreboard, stalls on RAW/WAW hazards, routes each accepted
// instruction into a registered valid/ready slot, serialises fence/fence.i and traps on illegal.
// Optional build macro ISSUE_WB_BYPASS_EN: a writeback valid this cycle masks its rd in the
// hazard check so a dependent can issue in the same cycle as the producer's writeback.

`ifndef ISSUE_CTRL_DEFS
`define ISSUE_CTRL_DEFS
`define OT_INT      3'd0
`define OT_BRANCH   3'd1
`define OT_LOAD     3'd2
`define OT_STORE    3'd3
`define OT_CSR      3'd4
`define OT_FENCE    3'd5
`define D_OPR1_RS1  2'd0
`define D_OPR1_PC   2'd1
`define D_OPR1_ZERO 2'd2
`define D_OPR2_RS2  2'd0
`define D_OPR2_IMM  2'd1
`endif

module issue_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [2:0]          dec_op_type,
  input  logic                dec_legal,
  input  logic                dec_wb_en,
  input  logic [1:0]          dec_operand1,
  input  logic [1:0]          dec_operand2,
  input  logic [REG_W-1:0]    dec_rs1,
  input  logic [REG_W-1:0]    dec_rs2,
  input  logic [REG_W-1:0]    dec_rd,
  input  logic                dec_fencei,
  output logic                ix_valid,
  input  logic                ix_ready,
  output logic                lsp_valid,
  input  logic                lsp_ready,
  output logic                csr_valid,
  input  logic                csr_ready,
  input  logic                ix_idle,
  input  logic                lsp_idle,
  input  logic                ix_wb_valid,
  input  logic [REG_W-1:0]    ix_wb_rd,
  input  logic                ls_wb_valid,
  input  logic [REG_W-1:0]    ls_wb_rd,
  input  logic                pipe_flush,
  output logic                fencei_flush,
  output logic                illegal_trap,
  output logic [NUM_REGS-1:0] sb_busy
);

  typedef enum logic [1:0] {StRun, StDrain, StFlush, StTrap} state_e;

  state_e              state_q;
  logic                fencei_q;
  logic                fencei_flush_q, illegal_trap_q;
  logic                ix_valid_q, ix_valid_d;
  logic                lsp_valid_q, lsp_valid_d;
  logic                csr_valid_q, csr_valid_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [NUM_REGS-1:0] busy_eff, set_vec, clr_vec;
  logic is_ix, is_ls, is_csr, is_fence, hazard, slot_free;
  logic acc, acc_disp, acc_fence, acc_illegal, drained;

  // Scoreboard view used by the hazard check (optionally bypassing same-cycle writebacks).
  always_comb begin
    busy_eff = sb_q;
`ifdef ISSUE_WB_BYPASS_EN
    if (ix_wb_valid) busy_eff[ix_wb_rd] = 1'b0;
    if (ls_wb_valid) busy_eff[ls_wb_rd] = 1'b0;
`endif
  end

  // Decode routing, hazard and slot availability; derive the accept strobes.
  always_comb begin
    is_ix    = (dec_op_type == `OT_INT) || (dec_op_type == `OT_BRANCH);
    is_ls    = (dec_op_type == `OT_LOAD) || (dec_op_type == `OT_STORE);
    is_csr   = (dec_op_type == `OT_CSR);
    is_fence = (dec_op_type == `OT_FENCE);
    hazard   = ((dec_operand1 == `D_OPR1_RS1) && busy_eff[dec_rs1]) ||
               ((dec_operand2 == `D_OPR2_RS2) && busy_eff[dec_rs2]) ||
               (dec_wb_en && busy_eff[dec_rd]);
    if (is_ix)       slot_free = !ix_valid_q || ix_ready;
    else if (is_ls)  slot_free = !lsp_valid_q || lsp_ready;
    else if (is_csr) slot_free = !csr_valid_q || csr_ready;
    else             slot_free = 1'b1;
    // Illegal instructions and fences never dispatch, so they skip hazard and slot checks.
    dec_ready   = (state_q == StRun) && !pipe_flush &&
                  (!dec_legal || is_fence || (!hazard && slot_free));
    acc         = dec_valid && dec_ready;
    acc_disp    = acc && dec_legal && !is_fence;
    acc_fence   = acc && dec_legal && is_fence;
    acc_illegal = acc && !dec_legal;
    drained     = !ix_valid_q && !lsp_valid_q && !csr_valid_q && ix_idle && lsp_idle &&
                  (sb_q == '0);
  end

  // Next state of the dispatch slots and scoreboard; a set beats a clear on the same register.
  always_comb begin
    ix_valid_d  = acc_disp && is_ix  ? 1'b1 : (ix_ready  ? 1'b0 : ix_valid_q);
    lsp_valid_d = acc_disp && is_ls  ? 1'b1 : (lsp_ready ? 1'b0 : lsp_valid_q);
    csr_valid_d = acc_disp && is_csr ? 1'b1 : (csr_ready ? 1'b0 : csr_valid_q);
    set_vec = '0;
    clr_vec = '0;
    if (acc_disp && dec_wb_en) set_vec[dec_rd] = 1'b1;
    if (ix_wb_valid) clr_vec[ix_wb_rd] = 1'b1;
    if (ls_wb_valid) clr_vec[ls_wb_rd] = 1'b1;
    sb_d    = (sb_q & ~clr_vec) | set_vec;
    sb_d[0] = 1'b0;
    if (pipe_flush) begin
      ix_valid_d  = 1'b0;
      lsp_valid_d = 1'b0;
      csr_valid_d = 1'b0;
      sb_d        = '0;
    end
  end

  // Slot and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix_valid_q  <= 1'b0;
      lsp_valid_q <= 1'b0;
      csr_valid_q <= 1'b0;
      sb_q        <= '0;
    end else begin
      ix_valid_q  <= ix_valid_d;
      lsp_valid_q <= lsp_valid_d;
      csr_valid_q <= csr_valid_d;
      sb_q        <= sb_d;
    end
  end

  // Control FSM with registered one-cycle pulses; pipe_flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      fencei_q       <= 1'b0;
      fencei_flush_q <= 1'b0;
      illegal_trap_q <= 1'b0;
    end else begin
      fencei_flush_q <= 1'b0;
      illegal_trap_q <= 1'b0;
      if (pipe_flush) begin
        state_q  <= StRun;
        fencei_q <= 1'b0;
      end else begin
        case (state_q)
          StRun: begin
            if (acc_illegal) begin
              state_q        <= StTrap;
              illegal_trap_q <= 1'b1;
            end else if (acc_fence) begin
              state_q  <= StDrain;
              fencei_q <= dec_fencei;
            end
          end
          StDrain: begin
            if (drained) begin
              if (fencei_q) begin
                state_q        <= StFlush;
                fencei_flush_q <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end
          end
          StFlush: state_q <= StRun;
          StTrap:  state_q <= StTrap;
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign ix_valid     = ix_valid_q;
  assign lsp_valid    = lsp_valid_q;
  assign csr_valid    = csr_valid_q;
  assign sb_busy      = sb_q;
  assign fencei_flush = fencei_flush_q;
  assign illegal_trap = illegal_trap_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.

`ifndef ISSUE_CTRL_DEFS
`define ISSUE_CTRL_DEFS
`define OT_INT      3'd0
`define OT_BRANCH   3'd1
`define OT_LOAD     3'd2
`define OT_STORE    3'd3
`define OT_CSR      3'd4
`define OT_FENCE    3'd5
`define D_OPR1_RS1  2'd0
`define D_OPR1_PC   2'd1
`define D_OPR1_ZERO 2'd2
`define D_OPR2_RS2  2'd0
`define D_OPR2_IMM  2'd1
`endif

module tb_issue_ctrl;

  logic        clk, rst_n;
  logic        dec_valid, dec_ready, dec_legal, dec_wb_en, dec_fencei;
  logic [2:0]  dec_op_type;
  logic [1:0]  dec_operand1, dec_operand2;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        ix_valid, ix_ready, lsp_valid, lsp_ready, csr_valid, csr_ready;
  logic        ix_idle, lsp_idle, ix_wb_valid, ls_wb_valid, pipe_flush;
  logic [4:0]  ix_wb_rd, ls_wb_rd;
  logic        fencei_flush, illegal_trap;
  logic [31:0] sb_busy;

  int n_cmp = 0;
  int n_bad = 0;

  issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op_type(dec_op_type),
    .dec_legal(dec_legal), .dec_wb_en(dec_wb_en), .dec_operand1(dec_operand1),
    .dec_operand2(dec_operand2), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_fencei(dec_fencei),
    .ix_valid(ix_valid), .ix_ready(ix_ready), .lsp_valid(lsp_valid), .lsp_ready(lsp_ready),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .ix_idle(ix_idle), .lsp_idle(lsp_idle),
    .ix_wb_valid(ix_wb_valid), .ix_wb_rd(ix_wb_rd), .ls_wb_valid(ls_wb_valid),
    .ls_wb_rd(ls_wb_rd), .pipe_flush(pipe_flush), .fencei_flush(fencei_flush),
    .illegal_trap(illegal_trap), .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dec_valid = 1'b0; dec_op_type = `OT_INT; dec_legal = 1'b1; dec_wb_en = 1'b0;
    dec_operand1 = `D_OPR1_ZERO; dec_operand2 = `D_OPR2_IMM;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_fencei = 1'b0;
    ix_ready = 1'b1; lsp_ready = 1'b1; csr_ready = 1'b1; ix_idle = 1'b1; lsp_idle = 1'b1;
    ix_wb_valid = 1'b0; ix_wb_rd = 5'd0; ls_wb_valid = 1'b0; ls_wb_rd = 5'd0;
    pipe_flush = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic legal, input logic wb,
                       input logic [1:0] o1, input logic [1:0] o2, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic fi);
    dec_valid = 1'b1; dec_op_type = op; dec_legal = legal; dec_wb_en = wb;
    dec_operand1 = o1; dec_operand2 = o2; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_fencei = fi;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  localparam int MRun = 0, MDrain = 1, MFlush = 2, MTrap = 3;
  int m_mode;
  bit m_fencei, m_ix, m_ls, m_csr, m_ff, m_trap;
  int m_pend[$];   // registers with an outstanding write

  function automatic bit pend_has(input int r);
    foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
    if (ix_wb_valid && int'(ix_wb_rd) == r) return 1'b0;
    if (ls_wb_valid && int'(ls_wb_rd) == r) return 1'b0;
`endif
    return pend_has(r);
  endfunction

  function automatic bit m_ready();
    bit haz, free;
    if (m_mode != MRun || pipe_flush) return 1'b0;
    if (!dec_legal || dec_op_type == `OT_FENCE) return 1'b1;
    haz = (dec_operand1 == `D_OPR1_RS1 && m_busy(int'(dec_rs1))) ||
          (dec_operand2 == `D_OPR2_RS2 && m_busy(int'(dec_rs2))) ||
          (dec_wb_en && m_busy(int'(dec_rd)));
    case (dec_op_type)
      `OT_INT, `OT_BRANCH:  free = !m_ix || ix_ready;
      `OT_LOAD, `OT_STORE:  free = !m_ls || lsp_ready;
      `OT_CSR:              free = !m_csr || csr_ready;
      default:              free = 1'b1;
    endcase
    return !haz && free;
  endfunction

  task automatic m_reset();
    m_mode = MRun; m_fencei = 0; m_ix = 0; m_ls = 0; m_csr = 0; m_ff = 0; m_trap = 0;
    m_pend.delete();
  endtask

  task automatic pend_remove(input int r);
    for (int i = m_pend.size() - 1; i >= 0; i--) if (m_pend[i] == r) m_pend.delete(i);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_step();
    bit acc, drained;
    acc = dec_valid && m_ready();
    drained = !m_ix && !m_ls && !m_csr && ix_idle && lsp_idle && (m_pend.size() == 0);
    m_ff = 0;
    m_trap = 0;
    if (pipe_flush) begin
      m_pend.delete(); m_ix = 0; m_ls = 0; m_csr = 0; m_mode = MRun; m_fencei = 0;
      return;
    end
    if (ix_ready) m_ix = 0;
    if (lsp_ready) m_ls = 0;
    if (csr_ready) m_csr = 0;
    if (ix_wb_valid) pend_remove(int'(ix_wb_rd));
    if (ls_wb_valid) pend_remove(int'(ls_wb_rd));
    if (acc && dec_legal && dec_op_type != `OT_FENCE) begin
      if (dec_op_type == `OT_INT || dec_op_type == `OT_BRANCH) m_ix = 1;
      if (dec_op_type == `OT_LOAD || dec_op_type == `OT_STORE) m_ls = 1;
      if (dec_op_type == `OT_CSR) m_csr = 1;
      if (dec_wb_en && dec_rd != 0 && !pend_has(int'(dec_rd))) m_pend.push_back(int'(dec_rd));
    end
    case (m_mode)
      MRun: begin
        if (acc && !dec_legal) begin m_mode = MTrap; m_trap = 1; end
        else if (acc && dec_op_type == `OT_FENCE) begin m_mode = MDrain; m_fencei = dec_fencei; end
      end
      MDrain: if (drained) begin
        if (m_fencei) begin m_mode = MFlush; m_ff = 1; end
        else m_mode = MRun;
      end
      MFlush: m_mode = MRun;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    v = '0;
    foreach (m_pend[i]) v[m_pend[i]] = 1'b1;
    return v;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] op; logic legal; logic wb; logic [1:0] o1; logic [4:0] rs1; logic [4:0] rd;
    logic flush; logic valid;
    logic e_ready; logic e_ix; logic e_ls; logic e_csr; logic e_trap; logic [31:0] e_sb;
  } vec_t;

  vec_t vecs[10];
  bit   exp_r;

  initial begin
    // op, legal, wb, opr1, rs1, rd, flush, valid | ready, ix, ls, csr, trap, sb
    vecs[0] = '{`OT_INT,    1'b1, 1'b1, `D_OPR1_RS1, 5'd1, 5'd5, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020};
    vecs[1] = '{`OT_BRANCH, 1'b1, 1'b0, `D_OPR1_RS1, 5'd2, 5'd0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{`OT_LOAD,   1'b1, 1'b1, `D_OPR1_RS1, 5'd3, 5'd9, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200};
    vecs[3] = '{`OT_STORE,  1'b1, 1'b0, `D_OPR1_RS1, 5'd3, 5'd0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{`OT_CSR,    1'b1, 1'b1, `D_OPR1_PC,  5'd0, 5'd2, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004};
    vecs[5] = '{`OT_FENCE,  1'b1, 1'b1, `D_OPR1_RS1, 5'd0, 5'd4, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{`OT_INT,    1'b0, 1'b1, `D_OPR1_RS1, 5'd1, 5'd6, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{`OT_INT,    1'b1, 1'b1, `D_OPR1_RS1, 5'd1, 5'd0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{`OT_INT,    1'b1, 1'b1, `D_OPR1_RS1, 5'd1, 5'd5, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{`OT_INT,    1'b1, 1'b1, `D_OPR1_RS1, 5'd1, 5'd5, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state, sampled while reset is held.
    idle_in();
    rst_n = 1'b0;
    #12;
    chk("rst_sb", sb_busy, 32'h0);
    chk("rst_valids", {29'h0, ix_valid, lsp_valid, csr_valid}, 32'h0);
    chk("rst_pulses", {30'h0, fencei_flush, illegal_trap}, 32'h0);
    chk("rst_ready", {31'h0, dec_ready}, 32'h1);
    do_reset();

    // Table-driven single-instruction checks from a clean state.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      drive(vecs[i].op, vecs[i].legal, vecs[i].wb, vecs[i].o1, `D_OPR2_IMM, vecs[i].rs1,
            5'd0, vecs[i].rd, 1'b0);
      dec_valid  = vecs[i].valid;
      pipe_flush = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'h0, dec_ready}, {31'h0, vecs[i].e_ready});
      cyc();
      dec_valid = 1'b0;
      pipe_flush = 1'b0;
      chk($sformatf("vec%0d_slots", i), {29'h0, ix_valid, lsp_valid, csr_valid},
          {29'h0, vecs[i].e_ix, vecs[i].e_ls, vecs[i].e_csr});
      chk($sformatf("vec%0d_trap", i), {31'h0, illegal_trap}, {31'h0, vecs[i].e_trap});
      chk($sformatf("vec%0d_sb", i), sb_busy, vecs[i].e_sb);
    end

    // RAW stall on x5 released by an int writeback presented in cycle 4.
    do_reset();
    drive(`OT_INT, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge clk);
    chk("raw_c0_ready", {31'h0, dec_ready}, 32'h1);
    cyc();
    chk("raw_c1_ix", {31'h0, ix_valid}, 32'h1);
    chk("raw_c1_sb", sb_busy, 32'h0000_0020);
    drive(`OT_INT, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_RS2, 5'd5, 5'd6, 5'd8, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      ix_wb_valid = (c == 4);
      ix_wb_rd = 5'd5;
`ifdef ISSUE_WB_BYPASS_EN
      exp_r = (c >= 4);
`else
      exp_r = (c >= 5);
`endif
      @(negedge clk);
      chk($sformatf("raw_c%0d_ready", c), {31'h0, dec_ready}, {31'h0, exp_r});
      cyc();
      ix_wb_valid = 1'b0;
      if (exp_r) break;
    end
    dec_valid = 1'b0;
    chk("raw_end_sb", sb_busy, 32'h0000_0100);

    // Load to x0 then store of x0 behind a stalled LS slot.
    do_reset();
    lsp_ready = 1'b0;
    drive(`OT_LOAD, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd2, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("ls_c0_ready", {31'h0, dec_ready}, 32'h1);
    cyc();
    drive(`OT_STORE, 1'b1, 1'b0, `D_OPR1_RS1, `D_OPR2_RS2, 5'd2, 5'd0, 5'd0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("ls_c%0d_ready", c), {31'h0, dec_ready}, 32'h0);
      chk($sformatf("ls_c%0d_lsp", c), {31'h0, lsp_valid}, 32'h1);
      chk($sformatf("ls_c%0d_sb", c), sb_busy, 32'h0);
      cyc();
    end
    lsp_ready = 1'b1;
    @(negedge clk);
    chk("ls_c4_ready", {31'h0, dec_ready}, 32'h1);
    cyc();
    dec_valid = 1'b0;
    chk("ls_c5_lsp", {31'h0, lsp_valid}, 32'h1);
    chk("ls_c5_sb", sb_busy, 32'h0);
    cyc();
    chk("ls_c6_lsp", {31'h0, lsp_valid}, 32'h0);

    // fence.i drains on x7 pending and a busy LS pipe, then pulses fencei_flush once.
    do_reset();
    lsp_idle = 1'b0;
    drive(`OT_LOAD, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd1, 5'd0, 5'd7, 1'b0);
    cyc();
    chk("fi_sb7", sb_busy, 32'h0000_0080);
    drive(`OT_FENCE, 1'b1, 1'b0, `D_OPR1_ZERO, `D_OPR2_IMM, 5'd0, 5'd0, 5'd0, 1'b1);
    @(negedge clk);
    chk("fi_accept", {31'h0, dec_ready}, 32'h1);
    cyc();
    drive(`OT_INT, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd1, 5'd0, 5'd1, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      ls_wb_valid = (c == 5);
      ls_wb_rd = 5'd7;
      lsp_idle = (c >= 7);
      @(negedge clk);
      chk($sformatf("fi_c%0d_ready", c), {31'h0, dec_ready}, 32'h0);
      chk($sformatf("fi_c%0d_ff", c), {31'h0, fencei_flush}, 32'h0);
      cyc();
      ls_wb_valid = 1'b0;
    end
    @(negedge clk);
    chk("fi_c8_ff", {31'h0, fencei_flush}, 32'h1);
    chk("fi_c8_ready", {31'h0, dec_ready}, 32'h0);
    cyc();
    @(negedge clk);
    chk("fi_c9_ff", {31'h0, fencei_flush}, 32'h0);
    chk("fi_c9_ready", {31'h0, dec_ready}, 32'h1);
    cyc();
    dec_valid = 1'b0;

    // Illegal instruction: single trap pulse, stays stalled until pipe_flush.
    do_reset();
    drive(`OT_INT, 1'b0, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd1, 5'd0, 5'd4, 1'b0);
    cyc();
    chk("ill_trap1", {31'h0, illegal_trap}, 32'h1);
    chk("ill_noslot", {29'h0, ix_valid, lsp_valid, csr_valid}, 32'h0);
    drive(`OT_INT, 1'b1, 1'b1, `D_OPR1_RS1, `D_OPR2_IMM, 5'd1, 5'd0, 5'd4, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("ill_stall%0d", c), {31'h0, dec_ready}, 32'h0);
      cyc();
      if (c == 0) chk("ill_trap0", {31'h0, illegal_trap}, 32'h0);
    end
    pipe_flush = 1'b1;
    @(negedge clk);
    chk("ill_flush_ready", {31'h0, dec_ready}, 32'h0);
    cyc();
    pipe_flush = 1'b0;
    @(negedge clk);
    chk("ill_after_flush", {31'h0, dec_ready}, 32'h1);
    cyc();
    dec_valid = 1'b0;

    // Same-cycle set and clear of x3: set wins. Then pipe_flush clears slot and scoreboard.
    do_reset();
    drive(`OT_INT, 1'b1, 1'b1, `D_OPR1_ZERO, `D_OPR2_IMM, 5'd0, 5'd0, 5'd3, 1'b0);
    ix_wb_valid = 1'b1;
    ix_wb_rd = 5'd3;
    cyc();
    dec_valid = 1'b0;
    ix_wb_valid = 1'b0;
    ix_ready = 1'b0;
    chk("setwin_sb", sb_busy, 32'h0000_0008);
    chk("setwin_ix", {31'h0, ix_valid}, 32'h1);
    pipe_flush = 1'b1;
    cyc();
    pipe_flush = 1'b0;
    chk("flush_ix", {31'h0, ix_valid}, 32'h0);
    chk("flush_sb", sb_busy, 32'h0);

    // Reset asserted mid-drain returns to RUN immediately and never emits fencei_flush.
    do_reset();
    lsp_idle = 1'b0;
    drive(`OT_FENCE, 1'b1, 1'b0, `D_OPR1_ZERO, `D_OPR2_IMM, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc();
    dec_valid = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstdrain_ready", {31'h0, dec_ready}, 32'h1);
    chk("rstdrain_ff", {31'h0, fencei_flush}, 32'h0);
    lsp_idle = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("rstdrain_noff%0d", c), {31'h0, fencei_flush}, 32'h0);
    end

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 800; c++) begin
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_op_type  = 3'($urandom_range(0, 5));
      if (dec_op_type == `OT_FENCE && $urandom_range(0, 2) != 0) dec_op_type = `OT_INT;
      dec_legal    = ($urandom_range(0, 24) != 0);
      dec_wb_en    = 1'($urandom_range(0, 1));
      dec_operand1 = 2'($urandom_range(0, 2));
      dec_operand2 = 2'($urandom_range(0, 1));
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      dec_fencei   = 1'($urandom_range(0, 1));
      ix_ready     = ($urandom_range(0, 3) != 0);
      lsp_ready    = ($urandom_range(0, 3) != 0);
      csr_ready    = ($urandom_range(0, 3) != 0);
      ix_idle      = ($urandom_range(0, 3) != 0);
      lsp_idle     = ($urandom_range(0, 3) != 0);
      pipe_flush   = ($urandom_range(0, 29) == 0);
      ix_wb_valid  = ($urandom_range(0, 2) == 0);
      ls_wb_valid  = ($urandom_range(0, 2) == 0);
      if (m_pend.size() != 0 && $urandom_range(0, 2) != 0)
        ix_wb_rd = 5'(m_pend[$urandom_range(0, m_pend.size() - 1)]);
      else
        ix_wb_rd = 5'($urandom_range(0, 7));
      if (m_pend.size() != 0 && $urandom_range(0, 2) != 0)
        ls_wb_rd = 5'(m_pend[$urandom_range(0, m_pend.size() - 1)]);
      else
        ls_wb_rd = 5'($urandom_range(0, 7));
      @(negedge clk);
      chk("rnd_ready", {31'h0, dec_ready}, {31'h0, m_ready()});
      m_step();
      cyc();
      chk("rnd_sb", sb_busy, m_vec());
      chk("rnd_slots", {29'h0, ix_valid, lsp_valid, csr_valid}, {29'h0, m_ix, m_ls, m_csr});
      chk("rnd_pulses", {30'h0, fencei_flush, illegal_trap}, {30'h0, m_ff, m_trap});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order single-issue dispatch controller between the decode unit and the execution pipes (integer/branch, load-store, CSR).
- Accepts one decoded instruction per cycle and tracks pending register writes in a 32-entry scoreboard. Stalls on RAW/WAW hazards.
- Routes each accepted instruction to its pipe through a registered valid/ready slot, serialises fence/fence.i and halts on illegal instructions until flushed.

Parameters:
- NUM_REGS, 32, architectural integer registers (scoreboard depth; x0 never tracked)
- REG_W, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  instruction accepted this cycle when dec_valid&&dec_ready
- dec_op_type  in  3  `OT_* code
- dec_legal  in  1  decoder legality
- dec_wb_en  in  1  instruction writes rd
- dec_operand1  in  2  `D_OPR1_*; rs1 read only when `D_OPR1_RS1
- dec_operand2  in  2  `D_OPR2_*; rs2 read when `D_OPR2_RS2
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
- dec_fencei  in  1  fence is fence.i
- ix_valid  out  1  int/branch pipe slot valid
- ix_ready  in  1  int pipe takes slot
- lsp_valid  out  1  LS pipe slot valid
- lsp_ready  in  1
- csr_valid  out  1  CSR pipe slot valid
- csr_ready  in  1
- ix_idle, lsp_idle  in  1 each  pipe holds no in-flight instruction
- ix_wb_valid  in  1, ix_wb_rd  in  5  int writeback
- ls_wb_valid  in  1, ls_wb_rd  in  5  load writeback
- pipe_flush  in  1  kill: clears slots, scoreboard, trap state
- fencei_flush  out  1  one-cycle pulse: fetch must flush
- illegal_trap  out  1  one-cycle pulse on accept of illegal instruction
- sb_busy  out  32  scoreboard vector (debug/verification)

Behaviour:
- Reset (rst_n low, async): state RUN; sb_busy=0; all *_valid, fencei_flush, illegal_trap = 0.
- Routing: OT_INT/OT_BRANCH→ix; OT_LOAD/OT_STORE→lsp; OT_CSR→csr; OT_FENCE→no slot.
- Hazard: rs1 used and sb_busy[rs1]; or rs2 used and sb_busy[rs2]; or dec_wb_en and sb_busy[rd]. Index 0 never busy.
- Slot free: target *_valid==0 or its ready==1 this cycle.
- dec_ready = (state==RUN) && !hazard && slot free && !pipe_flush. Illegal instructions and fences need no slot or hazard check.
- Accept of a legal non-fence: target *_valid=1 next cycle, so latency is 1. The slot holds until its ready is high. If dec_wb_en && rd!=0, sb_busy[rd] is set next cycle.
- Writeback: ix_wb_valid/ls_wb_valid clear sb_busy[rd] next cycle. If a set and a clear hit the same register in one cycle, the set wins. Both writebacks may clear different registers in the same cycle.
- Illegal accept (dec_legal=0): no dispatch, no scoreboard change, illegal_trap pulse, go TRAP.
- FSM:
  - RUN: on fence accept go to DRAIN.
  - DRAIN: dec_ready=0. Leave when all *_valid=0, ix_idle, lsp_idle and sb_busy==0. Go to FLUSH if the latched fencei=1, else RUN.
  - FLUSH: fencei_flush=1 for exactly one cycle, then RUN.
  - TRAP: dec_ready=0 until pipe_flush, then RUN.
- pipe_flush (any state, highest priority): next cycle all *_valid=0, sb_busy=0, state RUN, nothing accepted that cycle. Any pulse due that cycle is suppressed.
- rst_n asserted mid-DRAIN/FLUSH: immediate return to reset values; no fencei_flush emitted.

Optional Feature:
- ISSUE_WB_BYPASS_EN.
- Defined: a writeback valid this cycle masks its rd in the hazard check, so a dependent can be accepted in the same cycle the producer writes back. The operand is forwarded by the pipes.
- Undefined: hazard check uses the registered sb_busy only, so a dependent is accepted the cycle after writeback.

Test Plan:
- Reset, then dec addi rd=5 (OT_INT, wb_en) valid with ix_ready=1 → accepted cycle 0; ix_valid=1 cycle 1; sb_busy[5]=1 cycle 1.
- add rs1=5 behind it, ix_wb_rd=5 at cycle 4 → dec_ready=0 cycles 1–4, accept cycle 5 (cycle 4 with ISSUE_WB_BYPASS_EN).
- ld rd=0 then sd rs2=0 with lsp_ready=0 for 3 cycles → lsp_valid held 3 cycles, sd accepted only when lsp_ready=1; sb_busy stays 0.
- fence.i with sb_busy[7]=1, lsp_idle=0 → dec_ready=0 until ls_wb_rd=7 and lsp_idle=1; then fencei_flush pulses exactly 1 cycle, RUN after.
- Illegal instruction accepted → illegal_trap 1 cycle, no *_valid, dec_ready=0 for 10 cycles; pipe_flush → dec_ready=1 next cycle.
- Same-cycle accept rd=3 and ix_wb_rd=3 → sb_busy[3]=1 afterwards; pipe_flush with ix_valid=1 → ix_valid=0, sb_busy=0 next cycle.
